// File: rtl/firebird7_in_gate1_tessent_data_mux_seq_pkg.sv
// firebird7_in_gate1_tessent_data_mux_seq_pkg
// Shared definitions for the gate1 IJTAG data mux with break-before-make
// handover: the per-channel state encoding and the hold-counter limits.
package firebird7_in_gate1_tessent_data_mux_seq_pkg;

  // Per-channel handover state.
  typedef enum logic [1:0] {
    ST_FUNC   = 2'd0,  // functional data driving the output
    ST_HOLD_I = 2'd1,  // output frozen, moving towards IJTAG
    ST_IJTAG  = 2'd2,  // IJTAG data driving the output
    ST_HOLD_F = 2'd3   // output frozen, moving towards functional
  } chan_state_e;

  // Hold counter width and the largest SETTLE it can express.
  localparam int SETTLE_CNT_W = 4;
  localparam int SETTLE_MAX   = 15;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq_chan.sv
// firebird7_in_gate1_tessent_data_mux_seq_chan
// One mux channel. Selects functional or IJTAG data; any sampled change of
// select freezes the output at its last value for SETTLE extra edges before
// the new source is presented. A select reversal while frozen aborts the
// handover and returns to the original source.
// Ports:
//   ijtag_tck      - clock
//   ijtag_reset    - synchronous active-high reset
//   select         - requested source (1 = IJTAG)
//   func_data      - functional data
//   ijtag_data     - IJTAG override data
//   data_out       - muxed output
//   select_active  - 1 only while IJTAG data is driving
//   switching      - 1 while the output is frozen in a hold state
module firebird7_in_gate1_tessent_data_mux_seq_chan
  import firebird7_in_gate1_tessent_data_mux_seq_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             select,
  input  logic [WIDTH-1:0] func_data,
  input  logic [WIDTH-1:0] ijtag_data,
  output logic [WIDTH-1:0] data_out,
  output logic             select_active,
  output logic             switching
);

  // Counter load value: the hold lasts SETTLE+1 edges including the edge
  // that enters the hold state, so the counter starts at SETTLE-1.
  localparam logic [SETTLE_CNT_W-1:0] CNT_INIT =
    (SETTLE > 0) ? SETTLE_CNT_W'(SETTLE - 1) : '0;

  chan_state_e             state_q, state_d;
  logic [WIDTH-1:0]        hold_q, hold_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FUNC: begin
        if (select) begin
          if (SETTLE == 0) begin
            state_d = ST_IJTAG;
          end else begin
            state_d = ST_HOLD_I;
            hold_d  = func_data;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_IJTAG: begin
        if (!select) begin
          if (SETTLE == 0) begin
            state_d = ST_FUNC;
          end else begin
            state_d = ST_HOLD_F;
            hold_d  = ijtag_data;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_HOLD_I: begin
        if (!select) begin
          state_d = ST_FUNC;
        end else if (cnt_q == '0) begin
          state_d = ST_IJTAG;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD_F: begin
        if (select) begin
          state_d = ST_IJTAG;
        end else if (cnt_q == '0) begin
          state_d = ST_FUNC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_FUNC;
    endcase
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q <= ST_FUNC;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Steady states pass data straight through with no register in the path.
  always_comb begin
    data_out      = func_data;
    select_active = 1'b0;
    switching     = 1'b0;
    case (state_q)
      ST_FUNC:  data_out = func_data;
      ST_IJTAG: begin
        data_out      = ijtag_data;
        select_active = 1'b1;
      end
      ST_HOLD_I, ST_HOLD_F: begin
        data_out  = hold_q;
        switching = 1'b1;
      end
      default:  data_out = func_data;
    endcase
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// firebird7_in_gate1_tessent_data_mux_seq
// NCH independent functional/IJTAG data mux channels with break-before-make
// handover, plus a shared capture register that snapshots functional data
// for IJTAG readback.
// Ports:
//   ijtag_tck           - clock
//   ijtag_reset         - synchronous active-high reset
//   ijtag_select        - per-channel requested source (1 = IJTAG)
//   functional_data_in  - functional data, channel c at [c*WIDTH +: WIDTH]
//   ijtag_data_in       - IJTAG override data, same packing
//   capture_en          - snapshot functional_data_in at the next edge
//   data_out            - muxed output, same packing
//   capture_data_out    - registered functional snapshot
//   select_active       - per-channel: IJTAG currently driving
//   switching           - per-channel: hold in progress
module firebird7_in_gate1_tessent_data_mux_seq
  import firebird7_in_gate1_tessent_data_mux_seq_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int NCH    = 1,
  parameter int SETTLE = 2
) (
  input  logic                 ijtag_tck,
  input  logic                 ijtag_reset,
  input  logic [NCH-1:0]       ijtag_select,
  input  logic [NCH*WIDTH-1:0] functional_data_in,
  input  logic [NCH*WIDTH-1:0] ijtag_data_in,
  input  logic                 capture_en,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH*WIDTH-1:0] capture_data_out,
  output logic [NCH-1:0]       select_active,
  output logic [NCH-1:0]       switching
);

  // Elaboration-time parameter checks.
  generate
    if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_bad_settle
      $error("SETTLE must be in 0..%0d", SETTLE_MAX);
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("WIDTH must be at least 1");
    end
    if (NCH < 1) begin : g_bad_nch
      $error("NCH must be at least 1");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      firebird7_in_gate1_tessent_data_mux_seq_chan #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
      ) u_chan (
        .ijtag_tck     (ijtag_tck),
        .ijtag_reset   (ijtag_reset),
        .select        (ijtag_select[gi]),
        .func_data     (functional_data_in[gi*WIDTH +: WIDTH]),
        .ijtag_data    (ijtag_data_in[gi*WIDTH +: WIDTH]),
        .data_out      (data_out[gi*WIDTH +: WIDTH]),
        .select_active (select_active[gi]),
        .switching     (switching[gi])
      );
    end
  endgenerate

  // Capture is independent of channel state; it always sees functional data.
  logic [NCH*WIDTH-1:0] capture_q, capture_d;

  always_comb begin
    capture_d = capture_q;
    if (capture_en) begin
      capture_d = functional_data_in;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      capture_q <= '0;
    end else begin
      capture_q <= capture_d;
    end
  end

  assign capture_data_out = capture_q;

endmodule
